// File: rtl/conv_ofm_writer.sv
`default_nettype none
// ============================================================================
// Module      : conv_ofm_writer
// Description : Requantizes the transposed-convolution output stream, tags
//               each value with its linear OFM address and writes it to the
//               output feature-map SRAM through a small show-ahead FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_ofm_writer #(
    parameter int DATA_WIDTH = 48,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 8,
    parameter int OFM_SIZE   = 64,
    parameter int CO         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = $clog2(CO * OFM_SIZE * OFM_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_end,
    output logic                         mem_we,
    input  logic                         mem_ready,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [OUT_WIDTH-1:0]         mem_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         err_overflow,
    output logic                         err_short,
    output logic                         err_extra
);

    localparam int c_COL_W = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
    localparam int c_CH_W  = (CO > 1) ? $clog2(CO) : 1;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(OFM_SIZE - 1);
    localparam logic [c_CH_W-1:0]  c_CH_LAST  = c_CH_W'(CO - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

    // Half-LSB rounding bias; collapses to zero when FRAC_SHIFT is zero.
    localparam logic signed [DATA_WIDTH:0] c_ROUND =
        ({{DATA_WIDTH{1'b0}}, 1'b1} << FRAC_SHIFT) >> 1;
    localparam logic signed [DATA_WIDTH:0] c_QMAX =
        {{(DATA_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH:0] c_QMIN =
        {{(DATA_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;

    logic [c_COL_W-1:0] r_col;
    logic [c_COL_W-1:0] r_row;
    logic [c_CH_W-1:0]  r_ch;

    logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [OUT_WIDTH-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic signed [DATA_WIDTH:0] w_round;
    logic signed [DATA_WIDTH:0] w_shift;
    logic [OUT_WIDTH-1:0]       w_q;
    logic [ADDR_WIDTH-1:0]      w_addr;
    logic                       w_col_last;
    logic                       w_row_last;
    logic                       w_ch_last;
    logic                       w_last;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_accept;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_final;
    logic [c_CNT_W-1:0]         w_count_next;

    // ------------------------------------------------------------------
    // Requantization: round half-up, arithmetic shift, saturate.
    // ------------------------------------------------------------------
    always_comb begin
        w_round = $signed({in_data[DATA_WIDTH-1], in_data}) + c_ROUND;
        w_shift = w_round >>> FRAC_SHIFT;
        if (w_shift > c_QMAX) begin
            w_q = c_QMAX[OUT_WIDTH-1:0];
        end else if (w_shift < c_QMIN) begin
            w_q = c_QMIN[OUT_WIDTH-1:0];
        end else begin
            w_q = w_shift[OUT_WIDTH-1:0];
        end
    end

    assign w_addr = ADDR_WIDTH'(r_ch) * ADDR_WIDTH'(OFM_SIZE * OFM_SIZE)
                  + ADDR_WIDTH'(r_row) * ADDR_WIDTH'(OFM_SIZE)
                  + ADDR_WIDTH'(r_col);

    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_COL_LAST);
    assign w_ch_last  = (r_ch == c_CH_LAST);
    assign w_last     = w_col_last & w_row_last & w_ch_last;

    assign w_full   = (r_count == c_CNT_FULL);
    assign w_empty  = (r_count == '0);
    assign w_accept = (r_state == S_RUN) & in_valid & ~start;
    // A full FIFO drops the sample even if the head pops this same cycle.
    assign w_push   = w_accept & ~w_full;
    assign w_pop    = ~w_empty & mem_ready;
    assign w_final  = w_accept & w_last;

    assign w_count_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    assign mem_we    = ~w_empty;
    assign mem_addr  = r_fifo_addr[r_rd_ptr];
    assign mem_wdata = r_fifo_data[r_rd_ptr];

    // ------------------------------------------------------------------
    // Column / row / channel position counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
            r_ch  <= '0;
        end else if (start) begin
            r_col <= '0;
            r_row <= '0;
            r_ch  <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) begin
                    r_row <= '0;
                    r_ch  <= w_ch_last ? '0 : r_ch + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Elastic write FIFO; storage is reset so the head reads zero idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= w_addr;
                r_fifo_data[r_wr_ptr] <= w_q;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Layer control FSM with registered status outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
            err_extra    <= 1'b0;
        end else if (start) begin
            r_state      <= S_RUN;
            busy         <= 1'b1;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
            err_extra    <= 1'b0;
        end else begin
            if (w_accept && w_full) begin
                err_overflow <= 1'b1;
            end
            if (in_valid && (r_state != S_RUN)) begin
                err_extra <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                end
                S_RUN: begin
                    if (w_final || in_end) begin
                        r_state <= S_FLUSH;
                    end
                    if (in_end && !w_final) begin
                        err_short <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    // Look at the next count so done follows the last write directly.
                    if (w_count_next == '0) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_ofm_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_ofm_writer
// Description : Directed self-checking bench for conv_ofm_writer (4x4x2 OFM).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_ofm_writer;

    localparam int DW = 48;
    localparam int OW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_end = 1'b0;
    logic          mem_ready = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [OW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic          err_overflow;
    logic          err_short;
    logic          err_extra;

    conv_ofm_writer #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .FRAC_SHIFT (8),
        .OFM_SIZE   (4),
        .CO         (2),
        .FIFO_DEPTH (4),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_end       (in_end),
        .mem_we       (mem_we),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow),
        .err_short    (err_short),
        .err_extra    (err_extra)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int wr_cnt      = 0;
    int done_cnt    = 0;
    int last_wr_cyc = 0;
    int done_cyc    = 0;
    logic [AW+OW-1:0] exp_q [$];
    logic [AW+OW-1:0] mon_exp;
    logic [DW-1:0]    qin  [5];
    logic [OW-1:0]    qout [5];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write scoreboard sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && mem_we && mem_ready) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check_value("wr", {11'd0, mem_addr, mem_wdata}, {11'd0, mon_exp});
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] sval(input int a);
        return DW'((a * 3 + 5) * 256);
    endfunction

    task automatic exp_push(input int a);
        exp_q.push_back({AW'(a), OW'(a * 3 + 5)});
    endtask

    task automatic send(input int a);
        in_valid = 1'b1;
        in_data  = sval(a);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic begin_test();
        wr_cnt   = 0;
        done_cnt = 0;
        exp_q.delete();
    endtask

    task automatic end_test(input int n);
        repeat (12) tick();
        check_value("n_wr", 32'(wr_cnt), 32'(n));
        check_value("leftover", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        qin[0] = 48'h000000012380; qout[0] = 16'h0124;
        qin[1] = 48'h000000800000; qout[1] = 16'h7FFF;
        qin[2] = 48'hFFFFFFFFFF00; qout[2] = 16'hFFFF;
        qin[3] = 48'hFFFFFFFFFF80; qout[3] = 16'h0000;
        qin[4] = 48'hFFFF80000000; qout[4] = 16'h8000;

        // Reset state
        repeat (3) tick();
        check_value("rst_we", 32'(mem_we), 32'd0);
        check_value("rst_addr", 32'(mem_addr), 32'd0);
        check_value("rst_wdata", 32'(mem_wdata), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_err", 32'({err_overflow, err_short, err_extra}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full layer, back-to-back, memory always ready
        begin_test();
        for (int a = 0; a < 32; a++) exp_push(a);
        pulse_start();
        check_value("busy_run", 32'(busy), 32'd1);
        send(0);
        check_value("lat_we", 32'(mem_we), 32'd1);
        check_value("lat_addr", 32'(mem_addr), 32'd0);
        for (int a = 1; a < 32; a++) send(a);
        end_test(32);
        check_value("full_done_cnt", 32'(done_cnt), 32'd1);
        check_value("full_done_lat", 32'(done_cyc - last_wr_cyc), 32'd1);
        check_value("full_busy", 32'(busy), 32'd0);
        check_value("full_err", 32'({err_overflow, err_short, err_extra}), 32'd0);

        // Requantization corner values
        begin_test();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({AW'(i), qout[i]});
            in_valid = 1'b1;
            in_data  = qin[i];
            tick();
        end
        in_valid = 1'b0;
        end_test(5);

        // Backpressure: four held, fifth dropped
        begin_test();
        mem_ready = 1'b0;
        pulse_start();
        for (int a = 0; a < 5; a++) send(a);
        check_value("bp_ovf", 32'(err_overflow), 32'd1);
        check_value("bp_we", 32'(mem_we), 32'd1);
        check_value("bp_addr", 32'(mem_addr), 32'd0);
        check_value("bp_data", 32'(mem_wdata), 32'd5);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_value("bp_hold", {11'd0, mem_addr, mem_wdata}, {11'd0, 5'd0, 16'd5});
        end
        for (int a = 0; a < 32; a++) if (a != 4) exp_push(a);
        mem_ready = 1'b1;
        repeat (6) tick();
        for (int a = 5; a < 32; a++) send(a);
        end_test(31);
        check_value("bp_ovf_sticky", 32'(err_overflow), 32'd1);
        check_value("bp_done_cnt", 32'(done_cnt), 32'd1);

        // Early in_end after 20 samples
        begin_test();
        pulse_start();
        check_value("clr_ovf", 32'(err_overflow), 32'd0);
        for (int a = 0; a < 20; a++) begin
            exp_push(a);
            send(a);
        end
        in_end = 1'b1;
        tick();
        in_end = 1'b0;
        check_value("short_err", 32'(err_short), 32'd1);
        end_test(20);
        check_value("short_done_cnt", 32'(done_cnt), 32'd1);
        check_value("extra_pre", 32'(err_extra), 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_value("extra_err", 32'(err_extra), 32'd1);

        // Abort with three entries pending
        begin_test();
        mem_ready = 1'b0;
        pulse_start();
        check_value("ab_clr", 32'({err_short, err_extra}), 32'd0);
        for (int a = 0; a < 3; a++) send(a);
        in_end = 1'b1;
        tick();
        in_end = 1'b0;
        check_value("ab_short", 32'(err_short), 32'd1);
        check_value("ab_pending", 32'(mem_we), 32'd1);
        pulse_start();
        check_value("ab_empty", 32'(mem_we), 32'd0);
        check_value("ab_flags", 32'({err_overflow, err_short, err_extra}), 32'd0);
        check_value("ab_busy", 32'(busy), 32'd1);
        mem_ready = 1'b1;
        exp_q.push_back({5'd0, 16'd26});
        send(7);
        in_end = 1'b1;
        tick();
        in_end = 1'b0;
        end_test(1);

        // Asynchronous reset while a write is pending
        begin_test();
        mem_ready = 1'b0;
        pulse_start();
        send(0);
        send(1);
        check_value("ar_pre_we", 32'(mem_we), 32'd1);
        check_value("ar_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("ar_we", 32'(mem_we), 32'd0);
        check_value("ar_busy", 32'(busy), 32'd0);
        check_value("ar_done", 32'(done), 32'd0);
        check_value("ar_addr", 32'(mem_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_value("ar_quiet", 32'(mem_we), 32'd0);
        end
        end_test(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_ofm_writer.md
Name: conv_ofm_writer

Overview:
Downstream stage of the transposed-convolution engine. Consumes the engine's output stream (out_valid / data_output / end_conv) and requantizes each wide partial sum to OUT_WIDTH with rounding and saturation. Tags each value with its linear OFM address (channel-major, then row, then column) and writes it to the output feature-map SRAM through a ready/valid port, using a small elastic FIFO. Reports completion and sticky error flags to the layer controller.

Parameters:
DATA_WIDTH, 48, width of incoming signed partial sums
OUT_WIDTH, 16, width of stored OFM words (signed)
FRAC_SHIFT, 8, arithmetic right shift applied during requantization (0 allowed)
OFM_SIZE, 64, output feature-map width = height
CO, 8, number of output channels per layer
FIFO_DEPTH, 4, entries in write FIFO (power of two, >=2)
ADDR_WIDTH, $clog2(CO*OFM_SIZE*OFM_SIZE), memory address width

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: arm writer for a new layer
in_valid  in  1  engine out_valid
in_data  in  DATA_WIDTH  engine data_output (signed)
in_end  in  1  engine end_conv
mem_we  out  1  write request (valid)
mem_ready  in  1  memory accepts write this cycle
mem_addr  out  ADDR_WIDTH  write address
mem_wdata  out  OUT_WIDTH  write data
busy  out  1  high in RUN or FLUSH
done  out  1  one-cycle pulse when layer fully written
err_overflow  out  1  sticky: sample dropped on full FIFO
err_short  out  1  sticky: in_end before CO*OFM_SIZE*OFM_SIZE samples
err_extra  out  1  sticky: in_valid while not in RUN

Behaviour:
- Reset: state IDLE; col/row/ch counters 0; FIFO empty; mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, all err flags 0.
- States: IDLE -> RUN on start. RUN -> FLUSH when the last sample (ch=CO-1, row=col=OFM_SIZE-1) is accepted, or when in_end is seen. FLUSH -> DONE when FIFO empty. DONE -> IDLE after one cycle; done=1 only in DONE.
- start in any state: counters and FIFO cleared, err flags cleared, go RUN. In-flight FIFO entries are discarded (abort).
- Requantize (combinational at input):
  - r = in_data + (FRAC_SHIFT>0 ? 1<<(FRAC_SHIFT-1) : 0), computed in DATA_WIDTH+1 bits.
  - q = r >>> FRAC_SHIFT.
  - Saturate q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Address = ch*OFM_SIZE*OFM_SIZE + row*OFM_SIZE + col.
- Counters: col increments per accepted sample and wraps at OFM_SIZE-1, carrying into row; row wraps and carries into ch.
- RUN + in_valid + FIFO not full: push {addr, q}; advance counters.
- RUN + in_valid + FIFO full: sample dropped; counters still advance (address alignment preserved); err_overflow set.
- Simultaneous push and pop when full is treated as full (drop). Push and pop on the same cycle with the FIFO not full: count unchanged.
- in_valid outside RUN: ignored; err_extra set.
- in_end in RUN before the final sample: err_short set, go FLUSH. in_end on the same cycle as the final sample: final sample pushed, no error.
- Output side: mem_we = FIFO not empty; mem_addr/mem_wdata = FIFO head (registered storage, show-ahead). Pop on mem_we & mem_ready.
- Latency: sample accepted at cycle N appears on mem_we at cycle N+1 when the FIFO was empty. mem_addr/mem_wdata hold stable while mem_we=1 and mem_ready=0.
- Asynchronous reset mid-layer: all state and flags clear immediately; no further writes.

Test Plan:
- OFM_SIZE=4, CO=2, FRAC_SHIFT=8, mem_ready=1; start, then 32 back-to-back samples -> 32 writes, addresses 0..31 in order. done pulses once, 1 cycle after the last write. No err flags.
- Quantization: 0x000000012380 -> 0x0124; 0x000000800000 -> 0x7FFF; 0xFFFFFFFFFF00 (-256) -> 0xFFFF; 0xFFFFFFFFFF80 (-128) -> 0x0000; 0xFFFF80000000 -> 0x8000.
- Backpressure: mem_ready=0 for 10 cycles during a stream. First 4 samples held with stable addr/data. Sample 5 dropped, err_overflow=1. Addresses of later writes skip the dropped index.
- in_end after 20 of 32 samples -> err_short=1, remaining FIFO drains, done pulses. A subsequent in_valid sets err_extra.
- start pulse mid-stream with 3 FIFO entries pending -> FIFO emptied next cycle, next sample written to address 0, flags cleared.
- Reset asserted asynchronously with mem_we=1 -> mem_we, busy, done drop to 0 without waiting for a clock edge.
